// File: rtl/led_fade_module.sv
// PWM LED fader: each channel ramps its duty linearly toward its on/off target.
// Optional LED_GAMMA_EN selects a quadratic duty-to-compare curve instead of linear.
module led_fade_module #(
  parameter int N_LED    = 3,
  parameter int PWM_BITS = 8,
  parameter int STEP_CNT = 48_827
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic [N_LED-1:0] LED_In,
  output logic [N_LED-1:0] LED_Out,
  output logic             Busy
);

  localparam int SW = (STEP_CNT > 0) ? $clog2(STEP_CNT + 1) : 1;
  localparam logic [SW-1:0]       STEP_TC = SW'(STEP_CNT);
  localparam logic [PWM_BITS-1:0] DMAX    = '1;
  localparam logic [PWM_BITS-1:0] PWM_TC  = DMAX - 1'b1;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  logic [N_LED-1:0]    target;
  logic [SW-1:0]       step_cnt;
  logic                step_tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty       [N_LED];
  logic [PWM_BITS-1:0] cmp        [N_LED];
  state_t              state      [N_LED];
  state_t              state_next [N_LED];
  logic                ramp_any;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      target   <= '0;
      step_cnt <= '0;
      pwm_cnt  <= '0;
    end else begin
      target   <= LED_In;
      step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
      pwm_cnt  <= (pwm_cnt == PWM_TC) ? '0 : pwm_cnt + 1'b1;
    end
  end

  assign step_tick = (step_cnt == STEP_TC);

  // Duty saturates at both ends; only moves on a prescaler tick.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < N_LED; i++) duty[i] <= '0;
    end else if (step_tick) begin
      for (int i = 0; i < N_LED; i++) begin
        if (target[i] && (duty[i] != DMAX))
          duty[i] <= duty[i] + 1'b1;
        else if (!target[i] && (duty[i] != '0))
          duty[i] <= duty[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < N_LED; i++) state[i] <= OFF;
    end else begin
      for (int i = 0; i < N_LED; i++) state[i] <= state_next[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N_LED; i++) begin
      state_next[i] = state[i];
      case (state[i])
        OFF:       if (target[i]) state_next[i] = RAMP_UP;
        RAMP_UP: begin
          if (!target[i])           state_next[i] = (duty[i] == '0) ? OFF : RAMP_DOWN;
          else if (duty[i] == DMAX) state_next[i] = ON;
        end
        ON:        if (!target[i]) state_next[i] = RAMP_DOWN;
        RAMP_DOWN: begin
          if (target[i])            state_next[i] = (duty[i] == DMAX) ? ON : RAMP_UP;
          else if (duty[i] == '0)   state_next[i] = OFF;
        end
        default:   state_next[i] = OFF;
      endcase
    end
  end

  always_comb begin
    ramp_any = 1'b0;
    for (int i = 0; i < N_LED; i++) begin
      if ((state_next[i] == RAMP_UP) || (state_next[i] == RAMP_DOWN)) ramp_any = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) Busy <= 1'b0;
    else        Busy <= ramp_any;
  end

`ifdef LED_GAMMA_EN
  // duty*(duty+1) keeps both endpoints exact after the shift.
  logic [2*PWM_BITS-1:0] prod [N_LED];

  always_comb begin
    for (int i = 0; i < N_LED; i++) begin
      prod[i] = (2*PWM_BITS)'(duty[i]) * ((2*PWM_BITS)'(duty[i]) + (2*PWM_BITS)'(1));
      cmp[i]  = prod[i][2*PWM_BITS-1:PWM_BITS];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < N_LED; i++) cmp[i] = duty[i];
  end
`endif

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      LED_Out <= '0;
    end else begin
      for (int i = 0; i < N_LED; i++) LED_Out[i] <= (pwm_cnt < cmp[i]);
    end
  end

endmodule

// File: tb/tb_led_fade_module.sv
// Directed bench for led_fade_module with a 4-bit PWM and a 16-clock step period.
// Edge numbers count rising edges since the last reset release; duty steps land on multiples of 16.
module tb_led_fade_module;

  localparam int N_LED    = 3;
  localparam int PWM_BITS = 4;
  localparam int STEP_CNT = 15;

  logic             CLK;
  logic             RST_n;
  logic [N_LED-1:0] LED_In;
  logic [N_LED-1:0] LED_Out;
  logic             Busy;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int c0, c1, c2;

  led_fade_module #(
    .N_LED   (N_LED),
    .PWM_BITS(PWM_BITS),
    .STEP_CNT(STEP_CNT)
  ) dut (
    .CLK    (CLK),
    .RST_n  (RST_n),
    .LED_In (LED_In),
    .LED_Out(LED_Out),
    .Busy   (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic clk1();
    @(posedge CLK);
    edge_n++;
    @(negedge CLK);
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) clk1();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // High clocks per channel over the 15 edges s..s+14 (one full PWM period).
  task automatic measure(input int s, output int h0, output int h1, output int h2);
    run_to(s);
    h0 = int'(LED_Out[0]); h1 = int'(LED_Out[1]); h2 = int'(LED_Out[2]);
    repeat (14) begin
      clk1();
      h0 += int'(LED_Out[0]); h1 += int'(LED_Out[1]); h2 += int'(LED_Out[2]);
    end
  endtask

  task automatic win(input string tag, input int s, input int e0, input int e1, input int e2);
    measure(s, c0, c1, c2);
    chk({tag, "_ch0"}, c0, e0);
    chk({tag, "_ch1"}, c1, e1);
    chk({tag, "_ch2"}, c2, e2);
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RST_n  = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    RST_n  = 1'b0;
    LED_In = '0;
    repeat (3) @(negedge CLK);
    chk("rst_led", int'(LED_Out), 0);
    chk("rst_busy", int'(Busy), 0);
    release_reset();

    run_to(3);
    chk("idle_led", int'(LED_Out), 0);
    chk("idle_busy", int'(Busy), 0);

    // ch0 full ramp up
    run_to(4);
    LED_In = 3'b001;
    run_to(5);
    chk("up_busy_e5", int'(Busy), 0);
    run_to(6);
    chk("up_busy_e6", int'(Busy), 1);
    chk("up_led_e6", int'(LED_Out), 0);
    win("up_d1", 17, 1, 0, 0);
    win("up_d2", 33, 2, 0, 0);
    win("up_d7", 113, 7, 0, 0);
    run_to(240);
    chk("up_busy_e240", int'(Busy), 1);
    run_to(241);
    chk("up_busy_e241", int'(Busy), 0);
    win("up_full", 241, 15, 0, 0);

    // crossfade ch0 -> ch1
    run_to(256);
    LED_In = 3'b010;
    run_to(257);
    chk("xf_busy_e257", int'(Busy), 0);
    run_to(258);
    chk("xf_busy_e258", int'(Busy), 1);
    win("xf_k1", 273, 14, 1, 0);
    win("xf_k8", 385, 7, 8, 0);
    win("xf_k14", 481, 1, 14, 0);
    run_to(496);
    chk("xf_busy_e496", int'(Busy), 1);
    run_to(497);
    chk("xf_busy_e497", int'(Busy), 0);
    win("xf_done", 497, 0, 15, 0);

    // ch2 mid-ramp reversal at duty 5
    run_to(512);
    LED_In = 3'b110;
    win("rev_d4", 577, 0, 15, 4);
    run_to(592);
    LED_In = 3'b010;
    win("rev_peak", 593, 0, 15, 5);
    win("rev_dn4", 609, 0, 15, 4);
    win("rev_dn1", 657, 0, 15, 1);
    run_to(672);
    chk("rev_busy_e672", int'(Busy), 1);
    run_to(673);
    chk("rev_busy_e673", int'(Busy), 0);
    win("rev_off", 673, 0, 15, 0);

    // asynchronous reset with outputs active
    run_to(688);
    LED_In = 3'b111;
    run_to(690);
    chk("pre_rst_busy", int'(Busy), 1);
    chk("pre_rst_led1", int'(LED_Out[1]), 1);
    #2;
    RST_n = 1'b0;
    #1;
    chk("async_rst_led", int'(LED_Out), 0);
    chk("async_rst_busy", int'(Busy), 0);
    LED_In = '0;
    repeat (3) @(negedge CLK);
    release_reset();

    // single-clock target glitch between ticks gives no duty step
    run_to(2);
    LED_In = 3'b001;
    run_to(3);
    LED_In = 3'b000;
    run_to(4);
    chk("glitch_busy_e4", int'(Busy), 1);
    run_to(5);
    chk("glitch_busy_e5", int'(Busy), 0);
    run_to(20);
    chk("glitch_led", int'(LED_Out), 0);
    chk("glitch_busy", int'(Busy), 0);
    win("glitch_win", 33, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
